// File: rtl/mysystem_mux_select_master.sv
// rtl/mysystem_mux_select_master.sv - Avalon-MM initiator driving a mux-select PIO port
//
// Accepts WRITE/SET/CLEAR/READ commands, issues one single-beat access to the
// PIO slave (data @0, bit-set @4, bit-clear @5), optionally reads the port back
// to confirm the update, and answers with a one-cycle response pulse.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   cmd_valid, cmd_ready               command handshake (ready only when idle)
//   cmd_op[1:0], cmd_data[31:0]        0 WRITE, 1 SET, 2 CLEAR, 3 READ; value / mask
//   rsp_valid, rsp_data, rsp_error     one-cycle response, no backpressure
//   address, chipselect, write_n,      Avalon-MM initiator outputs (all registered)
//   read_n, writedata
//   readdata, waitrequest              Avalon-MM slave returns (readdata latency 0)

module mysystem_mux_select_master #(
   parameter int PORT_WIDTH = 1,
   parameter int VERIFY     = 1,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_error,
   output logic [2:0]  address,
   output logic        chipselect,
   output logic        write_n,
   output logic        read_n,
   output logic [31:0] writedata,
   input  logic [31:0] readdata,
   input  logic        waitrequest
);

   typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   // Stall count at which the next stalled cycle reaches the limit.
   localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_SET   = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd3;

   state_t                  state;
   logic [1:0]              op;
   logic [PORT_WIDTH-1:0]   mask;
   logic [PORT_WIDTH-1:0]   shadow;
   logic [CW-1:0]           wait_cnt;
   logic [PORT_WIDTH-1:0]   wr_result;
   logic                    timeout_hit;

   assign cmd_ready = (state == IDLE);

   // The access is abandoned on the stalled cycle that brings the count to TIMEOUT.
   assign timeout_hit = (TIMEOUT > 0) && waitrequest && (32'(wait_cnt) == TO_LAST);

   // Port value the PIO holds once the pending write lands.
   always_comb begin
      wr_result = shadow;
      case (op)
         OP_WRITE: wr_result = mask;
         OP_SET:   wr_result = shadow | mask;
         default:  wr_result = shadow & ~mask;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         op         <= OP_WRITE;
         mask       <= '0;
         shadow     <= '0;
         wait_cnt   <= '0;
         address    <= 3'd0;
         chipselect <= 1'b0;
         write_n    <= 1'b1;
         read_n     <= 1'b1;
         writedata  <= 32'd0;
         rsp_valid  <= 1'b0;
         rsp_data   <= 32'd0;
         rsp_error  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op         <= cmd_op;
                  mask       <= cmd_data[PORT_WIDTH-1:0];
                  wait_cnt   <= '0;
                  chipselect <= 1'b1;
                  if (cmd_op == OP_READ) begin
                     state   <= RD;
                     read_n  <= 1'b0;
                     address <= 3'd0;
                  end else begin
                     state     <= WR;
                     write_n   <= 1'b0;
                     writedata <= cmd_data;
                     address   <= (cmd_op == OP_WRITE) ? 3'd0 :
                                  (cmd_op == OP_SET)   ? 3'd4 : 3'd5;
                  end
               end
            end

            WR: begin
               if (!waitrequest) begin
                  shadow  <= wr_result;
                  write_n <= 1'b1;
                  if (VERIFY != 0) begin
                     // Chipselect stays high: the readback follows directly.
                     state    <= RD;
                     read_n   <= 1'b0;
                     address  <= 3'd0;
                     wait_cnt <= '0;
                  end else begin
                     chipselect <= 1'b0;
                     state      <= RESP;
                     rsp_valid  <= 1'b1;
                     rsp_data   <= 32'(wr_result);
                     rsp_error  <= 1'b0;
                  end
               end else if (timeout_hit) begin
                  chipselect <= 1'b0;
                  write_n    <= 1'b1;
                  state      <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_data   <= 32'd0;
                  rsp_error  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            RD: begin
               if (!waitrequest) begin
                  chipselect <= 1'b0;
                  read_n     <= 1'b1;
                  state      <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_data   <= readdata;
                  if (op == OP_READ) begin
                     shadow    <= readdata[PORT_WIDTH-1:0];
                     rsp_error <= 1'b0;
                  end else begin
                     rsp_error <= (readdata[PORT_WIDTH-1:0] != shadow);
                  end
               end else if (timeout_hit) begin
                  chipselect <= 1'b0;
                  read_n     <= 1'b1;
                  state      <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_data   <= 32'd0;
                  rsp_error  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            RESP: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mysystem_mux_select_master.sv
// tb/tb_mysystem_mux_select_master.sv - bench for mysystem_mux_select_master

module tb_mysystem_mux_select_master;

   localparam int PW = 8;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_error;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;

   mysystem_mux_select_master #(
      .PORT_WIDTH(PW),
      .VERIFY(1),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_data(cmd_data),
      .rsp_valid(rsp_valid),
      .rsp_data(rsp_data),
      .rsp_error(rsp_error),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .read_n(read_n),
      .writedata(writedata),
      .readdata(readdata),
      .waitrequest(waitrequest)
   );

   always #5 clk = ~clk;

   // PIO slave: stalls each access for a programmed number of cycles.
   logic [PW-1:0] pio;
   int            scnt;
   int            stall_wr;
   int            stall_rd;
   logic          rd_ovr_en;
   logic [31:0]   rd_ovr_val;
   logic [31:0]   rd_junk;

   assign waitrequest = chipselect && (scnt < (write_n ? stall_rd : stall_wr));
   assign readdata    = rd_ovr_en ? rd_ovr_val : ({24'h0, pio} | rd_junk);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pio  <= '0;
         scnt <= 0;
      end else begin
         if (chipselect && waitrequest) scnt <= scnt + 1;
         else                           scnt <= 0;
         if (chipselect && !write_n && !waitrequest) begin
            case (address)
               3'd0:    pio <= writedata[PW-1:0];
               3'd4:    pio <= pio | writedata[PW-1:0];
               3'd5:    pio <= pio & ~writedata[PW-1:0];
               default: pio <= pio;
            endcase
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   // Reference: what the DUT should believe the port holds, and what the port holds.
   logic [PW-1:0] ref_shadow;
   logic [PW-1:0] ref_pio;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge one cycle after the response.
   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [31:0] d,
                          input int sw, input int sr, input logic ovr_en,
                          input logic [31:0] ovr_val, input logic [31:0] junk);
      logic [PW-1:0] dm, newv, pio_new;
      logic [31:0]   rdval, e_data, got_data;
      logic          e_err, got_err;
      logic [2:0]    e_addr;
      int            e_k, e_wc, e_rc, got_k, wc, rc, bad, wait_rdy;

      dm     = d[PW-1:0];
      e_addr = (op == 2'd0) ? 3'd0 : (op == 2'd1) ? 3'd4 : 3'd5;
      e_data = 32'd0;
      e_err  = 1'b0;
      if (op == 2'd3) begin
         e_wc = 0;
         if (sr >= TO) begin
            e_rc = TO; e_k = 1 + TO; e_err = 1'b1;
         end else begin
            e_rc = 1 + sr; e_k = 1 + e_rc;
            rdval = ovr_en ? ovr_val : ({24'h0, ref_pio} | junk);
            e_data = rdval;
            ref_shadow = rdval[PW-1:0];
         end
      end else begin
         case (op)
            2'd0:    begin newv = dm;               pio_new = dm;            end
            2'd1:    begin newv = ref_shadow | dm;  pio_new = ref_pio | dm;  end
            default: begin newv = ref_shadow & ~dm; pio_new = ref_pio & ~dm; end
         endcase
         if (sw >= TO) begin
            e_wc = TO; e_rc = 0; e_k = 1 + TO; e_err = 1'b1;
         end else begin
            e_wc = 1 + sw;
            ref_shadow = newv;
            ref_pio    = pio_new;
            if (sr >= TO) begin
               e_rc = TO; e_k = 1 + e_wc + TO; e_err = 1'b1;
            end else begin
               e_rc = 1 + sr; e_k = 1 + e_wc + e_rc;
               rdval  = ovr_en ? ovr_val : {24'h0, ref_pio};
               e_data = rdval;
               e_err  = (rdval[PW-1:0] != newv);
            end
         end
      end

      wait_rdy = 0;
      while (!cmd_ready && wait_rdy < 20) begin
         @(negedge clk);
         wait_rdy++;
      end
      check({tag, "_ready"}, cmd_ready, 1'b1);

      stall_wr = sw; stall_rd = sr;
      rd_ovr_en = ovr_en; rd_ovr_val = ovr_val; rd_junk = junk;
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data  = $urandom;

      got_k = 0; wc = 0; rc = 0; bad = 0;
      got_data = 32'hx; got_err = 1'bx;
      for (int k = 1; k <= 60; k++) begin
         if (chipselect && !write_n) begin
            wc++;
            if (address !== e_addr || writedata !== d) bad++;
         end
         if (chipselect && !read_n) begin
            rc++;
            if (address !== 3'd0) bad++;
         end
         if (rsp_valid) begin
            got_k = k; got_data = rsp_data; got_err = rsp_error;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_latency"}, got_k, e_k);
      check({tag, "_rsp_data"}, got_data, e_data);
      check({tag, "_rsp_error"}, {31'd0, got_err}, {31'd0, e_err});
      check({tag, "_wr_cycles"}, wc, e_wc);
      check({tag, "_rd_cycles"}, rc, e_rc);
      check({tag, "_bus_stable"}, bad, 0);
      @(negedge clk);
      check({tag, "_pulse_end"}, {rsp_valid, cmd_ready, chipselect}, 3'b010);
      rd_ovr_en = 1'b0; rd_junk = 32'd0; stall_wr = 0; stall_rd = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      logic [1:0]  rop;
      logic [31:0] rdat, rjunk, rov;
      logic        rovr;
      int          rsw, rsr;

      reset = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 32'hFF;
      stall_wr = 0; stall_rd = 0;
      rd_ovr_en = 1'b0; rd_ovr_val = 32'd0; rd_junk = 32'd0;
      ref_shadow = '0; ref_pio = '0;
      repeat (3) @(negedge clk);

      // Reset state, with a command presented during reset.
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_strobes", {chipselect, write_n, read_n}, 3'b011);
      check("rst_address", address, 3'd0);
      check("rst_writedata", writedata, 32'd0);
      check("rst_rsp", {rsp_valid, rsp_error}, 2'b00);
      check("rst_rsp_data", rsp_data, 32'd0);
      cmd_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_idle", {cmd_ready, chipselect}, 2'b10);

      // First READ with forced readdata of 1; shadow becomes 1.
      run_cmd("rd_first", 2'd3, 32'd0, 0, 0, 1'b1, 32'h1, 32'd0);
      // WRITE 1 / SET 1 / CLEAR 1 with verify readback.
      run_cmd("wr1", 2'd0, 32'h1, 0, 0, 1'b0, 32'd0, 32'd0);
      run_cmd("set1", 2'd1, 32'h1, 0, 0, 1'b0, 32'd0, 32'd0);
      run_cmd("clr1", 2'd2, 32'h1, 0, 0, 1'b0, 32'd0, 32'd0);
      // Corrupted readback after SET 1.
      run_cmd("set_corrupt", 2'd1, 32'h1, 0, 0, 1'b1, 32'h0, 32'd0);
      // Write stalled three cycles (largest stall that still completes).
      run_cmd("wr_stall3", 2'd0, 32'hA5A5_005A, 3, 0, 1'b0, 32'd0, 32'd0);
      // Write with waitrequest stuck high, then confirm shadow unchanged.
      run_cmd("wr_timeout", 2'd1, 32'h0000_0081, 100, 0, 1'b0, 32'd0, 32'd0);
      run_cmd("after_to", 2'd2, 32'h0, 0, 0, 1'b0, 32'd0, 32'd0);
      // Read and verify-read timeouts.
      run_cmd("rd_timeout", 2'd3, 32'd0, 0, 100, 1'b0, 32'd0, 32'd0);
      run_cmd("vrd_timeout", 2'd1, 32'h0000_0003, 1, 4, 1'b0, 32'd0, 32'd0);
      run_cmd("rd_raw", 2'd3, 32'd0, 0, 2, 1'b0, 32'd0, 32'hDEAD_BE00);

      // Reset during a stalled write.
      stall_wr = 1000;
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 32'h33;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("stall_before_rst", {chipselect, write_n}, 2'b10);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_strobes", {chipselect, write_n, read_n}, 3'b011);
      check("rst_mid_rsp", rsp_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      stall_wr = 0;
      ref_shadow = '0; ref_pio = '0;
      seen = 0;
      repeat (4) begin
         if (rsp_valid) seen++;
         @(negedge clk);
      end
      check("rst_mid_no_rsp", seen, 0);
      check("rst_mid_ready", {cmd_ready, chipselect}, 2'b10);

      // Randomized commands against the reference model.
      for (int i = 0; i < 40; i++) begin
         rop   = 2'($urandom_range(0, 3));
         rdat  = $urandom;
         rsw   = ($urandom_range(0, 5) == 0) ? 4 + $urandom_range(0, 2) : $urandom_range(0, 3);
         rsr   = ($urandom_range(0, 5) == 0) ? 4 : $urandom_range(0, 3);
         rovr  = ($urandom_range(0, 7) == 0);
         rov   = $urandom;
         rjunk = (rop == 2'd3) ? ($urandom & 32'hFFFF_FF00) : 32'd0;
         run_cmd($sformatf("rand%0d", i), rop, rdat, rsw, rsr, rovr, rov, rjunk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mysystem_mux_select_master.md
# mysystem_mux_select_master

Avalon-MM initiator that drives a memory-mapped PIO output port (data register at address 0, bit-set at address 4, bit-clear at address 5). It accepts simple commands from local control logic, issues the corresponding single-beat bus write or read, optionally reads the port back to verify the update, and returns a one-cycle response. It sits between the lab control FSM and the mux-select PIO slaves in the system interconnect.

## Interface
- PORT_WIDTH, 1: width of the target PIO data register (1..32).
- VERIFY, 1: 1 = read back address 0 after every write/set/clear and compare; 0 = no readback.
- TIMEOUT, 255: max consecutive waitrequest-high cycles per bus access; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_op  in  2  0 = WRITE, 1 = SET, 2 = CLEAR, 3 = READ.
- cmd_data  in  32  write value or bit mask (ignored for READ).
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_data  out  32  READ: raw readdata; other ops: readback value (VERIFY=1) or expected value (VERIFY=0).
- rsp_error  out  1  valid with rsp_valid: timeout or verify mismatch.
- address  out  3  Avalon address.
- chipselect  out  1  access strobe.
- write_n  out  1  active-low write.
- read_n  out  1  active-low read.
- writedata  out  32  write data.
- readdata  in  32  read data, valid in the cycle a read completes (latency 0).
- waitrequest  in  1  slave stall; tie 0 for PIO slaves.

## Operation
- States: IDLE, WR, RD, RESP.
- IDLE: cmd_ready=1. On cmd_valid: latch op/data; WRITE/SET/CLEAR -> WR with address 0/4/5 and writedata=cmd_data; READ -> RD with address 0.
- WR: chipselect=1, write_n=0. Completes in the first cycle with waitrequest=0. On completion update shadow: WRITE: data; SET: shadow|data; CLEAR: shadow&~data (all truncated to PORT_WIDTH). Then -> RD if VERIFY=1, else -> RESP.
- RD: chipselect=1, read_n=0, address=0. On completion capture readdata. READ op: shadow <= readdata[PORT_WIDTH-1:0], error=0. Verify read: error = (readdata[PORT_WIDTH-1:0] != shadow); upper readdata bits ignored.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
- Timeout (TIMEOUT>0): counter clears on entry to WR/RD and counts cycles with waitrequest=1; when it reaches TIMEOUT, the access is dropped (strobes deasserted next cycle), shadow unchanged, rsp_error=1, rsp_data=0, -> RESP. A timed-out write skips the verify read.
- Outputs held stable (address, writedata, strobes) for the full duration of a stalled access.
- Shadow resets to 0, matching the PIO register reset value.

## Timing
- Reset (async, immediate): state IDLE, cmd_ready=1, chipselect=0, write_n=1, read_n=1, address=0, writedata=0, rsp_valid=0, rsp_error=0, rsp_data=0, shadow=0, timeout counter=0. Commands presented while reset=1 are ignored. Reset mid-access drops strobes in the same cycle; no response is produced.
- Accept at edge N (cmd_valid & cmd_ready): bus access strobes from cycle N+1; all bus outputs registered.
- No stall, VERIFY=0: write at N+1, rsp_valid at N+2, cmd_ready at N+3.
- No stall, VERIFY=1 or READ: write N+1, read N+2, rsp_valid N+3 (READ only: read N+1, rsp_valid N+2).
- Each waitrequest-high cycle adds one cycle to the access.
- Back-to-back: the next command is accepted in the cycle after rsp_valid; minimum 3 cycles per command with VERIFY=0.
- cmd_valid while busy is not accepted and not dropped by this block; the requester holds it.

## Test plan
- Reset, then READ with readdata=32'h1, waitrequest=0 -> rd at address 0, rsp_valid 2 cycles after accept, rsp_data=32'h1, rsp_error=0, shadow=1.
- PORT_WIDTH=1, VERIFY=1: WRITE 1, SET 1, CLEAR 1 against a modelled PIO slave -> addresses 0/4/5 in sequence, each followed by a read at 0 returning 1,1,0; all rsp_error=0.
- VERIFY=1, slave model corrupts readback (returns 0 after SET 1) -> rsp_error=1, rsp_data=0.
- Write with waitrequest high 3 cycles -> write_n/address/writedata stable for 4 cycles, rsp_valid delayed by 3, rsp_error=0.
- TIMEOUT=4, waitrequest stuck high -> strobes drop after 4 stall cycles, rsp_error=1, shadow unchanged, next command accepted normally.
- Assert reset during a stalled write -> chipselect=0 and write_n=1 immediately, no rsp_valid, cmd_ready=1 once reset releases.
